eh2_lsu_dccm_wrbuf: RTL and testbench
=====================================

Name: eh2_lsu_dccm_wrbuf

Overview:
- Store write buffer directly upstream of the DCCM write port in the memory wrapper.
- Queues full-word ECC-encoded stores from the LSU commit stage and drains them to the DCCM lo write port when no load holds the array.
- Forwards buffered data to younger loads that hit a pending address.
- Bounds load-induced write starvation with a counter that forces a drain and stalls loads.

Parameters:
DCCM_BITS, 16, DCCM byte-address width.
DCCM_FDATA_WIDTH, 39, stored word width (32 data + 7 ECC).
DEPTH, 4, buffer entries (power of 2, 2..8).
STARVE_MAX, 7, blocked-drain cycles before a forced write.

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
st_valid  in  1  store request
st_ready  out  1  buffer can accept store
st_addr  in  DCCM_BITS  store word address (bits [1:0] ignored)
st_data  in  DCCM_FDATA_WIDTH  encoded store word
ld_rden  in  1  load wants DCCM read this cycle
ld_addr  in  DCCM_BITS  load word address (bits [1:0] ignored)
ld_stall  out  1  load must retry; forced drain owns the array
fwd_hit  out  1  ld_addr matches a valid entry
fwd_data  out  DCCM_FDATA_WIDTH  youngest matching entry data
flush_req  in  1  drain unconditionally (fence / debug halt)
dccm_wren  out  1  DCCM write enable
dccm_wr_addr_lo  out  DCCM_BITS  DCCM write address
dccm_wr_data_lo  out  DCCM_FDATA_WIDTH  DCCM write data
wb_count  out  $clog2(DEPTH)+1  valid entries
wb_idle  out  1  buffer empty

Behaviour:
- Circular FIFO: wr_ptr, rd_ptr, and count, all registered.
- Reset: all pointers, count, starve counter, and valid bits are 0.
- Reset values: st_ready=1, wb_idle=1, dccm_wren=0, fwd_hit=0, ld_stall=0, and all data outputs 0.
- Reset mid-operation discards every pending entry; no partial DCCM write is issued.
- st_ready = (count != DEPTH), taken from registered count only. A dequeue in the same cycle does not open a full buffer.
- Enqueue happens when st_valid & st_ready. The entry is written at wr_ptr on the next edge; wr_ptr wraps modulo DEPTH.
- Drain condition: drain = (count != 0) & (~ld_rden | flush_req | starve == STARVE_MAX).
- dccm_wren = drain. It is combinational, so the DCCM write occurs in the same cycle.
  - dccm_wr_addr_lo = head address with [1:0] forced to 0.
  - dccm_wr_data_lo = head data. Both are 0 when the buffer is empty.
- Dequeue occurs at the edge after a drain cycle; rd_ptr wraps modulo DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- ld_stall = ld_rden & drain. The load did not get the array and must replay.
- Starve counter:
  - Increments when count != 0, ld_rden is high, and no drain occurs. It saturates at STARVE_MAX.
  - Clears on any drain or when count == 0.
- Forwarding (combinational, same cycle as ld_rden):
  - Compare ld_addr[DCCM_BITS-1:2] against every valid entry.
  - fwd_hit = ld_rden & any match.
  - fwd_data = data of the youngest match, i.e. closest to wr_ptr-1; 0 if no hit.
  - The entry draining this cycle still participates.
  - A store enqueuing this cycle does not participate (visible next cycle).
- Multiple entries to the same address are kept and drained in order. Last-written data lands in the DCCM.
- wb_idle = (count == 0), registered-derived.

Test Plan:
- Reset release, st_valid=0 -> st_ready=1, wb_idle=1, dccm_wren=0, wb_count=0.
- Store addr 0x0104 data 0x12_3456789A with ld_rden=0 -> next cycle dccm_wren=1, addr 0x0104, data 0x12_3456789A; following cycle wb_count=0.
- 4 stores back-to-back with ld_rden held 1 -> wb_count=4 and st_ready=0 (5th store held). After 7 blocked cycles the 8th cycle gives dccm_wren=1 and ld_stall=1, starve cleared. Fill resumes next cycle.
- Stores to 0x0200 (data A) then 0x0200 (data B), then load 0x0202 -> fwd_hit=1, fwd_data=B. Load 0x0300 -> fwd_hit=0, fwd_data=0.
- Buffer holds 2 entries with ld_rden=1 and flush_req=1 -> drains on 2 consecutive cycles with ld_stall=1 each. wb_idle=1 on the third cycle.
- 3 entries pending, rst_l asserted low asynchronously mid-cycle -> dccm_wren=0 immediately, wb_count=0; after release no writes are issued.

Source files
------------

// File: rtl/eh2_lsu_dccm_wrbuf_if.sv
// Store/load/DCCM-write bundle between the LSU, the write buffer and the DCCM wrapper.
interface eh2_lsu_dccm_wrbuf_if #(
  parameter int unsigned DCCM_BITS        = 16,
  parameter int unsigned DCCM_FDATA_WIDTH = 39,
  parameter int unsigned DEPTH            = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                        st_valid;
  logic                        st_ready;
  logic [DCCM_BITS-1:0]        st_addr;
  logic [DCCM_FDATA_WIDTH-1:0] st_data;
  logic                        ld_rden;
  logic [DCCM_BITS-1:0]        ld_addr;
  logic                        ld_stall;
  logic                        fwd_hit;
  logic [DCCM_FDATA_WIDTH-1:0] fwd_data;
  logic                        flush_req;
  logic                        dccm_wren;
  logic [DCCM_BITS-1:0]        dccm_wr_addr_lo;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo;
  logic [CW-1:0]               wb_count;
  logic                        wb_idle;

  modport master (
    output st_valid, st_addr, st_data, ld_rden, ld_addr, flush_req,
    input  st_ready, ld_stall, fwd_hit, fwd_data, dccm_wren,
           dccm_wr_addr_lo, dccm_wr_data_lo, wb_count, wb_idle
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_rden, ld_addr, flush_req,
    output st_ready, ld_stall, fwd_hit, fwd_data, dccm_wren,
           dccm_wr_addr_lo, dccm_wr_data_lo, wb_count, wb_idle
  );
endinterface

// File: rtl/eh2_lsu_dccm_wrbuf.sv
// DCCM store write buffer: FIFO of encoded stores drained when loads leave the
// array free, with youngest-match load forwarding and a starvation breaker.
module eh2_lsu_dccm_wrbuf #(
  parameter int unsigned DCCM_BITS        = 16,
  parameter int unsigned DCCM_FDATA_WIDTH = 39,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned STARVE_MAX       = 7
) (
  input logic                  clk,
  input logic                  rst_l,
  eh2_lsu_dccm_wrbuf_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned AW = DCCM_BITS - 2;
  localparam int unsigned DW = DCCM_FDATA_WIDTH;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic          not_empty, starved, drain, enq;
  logic          hit_any;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;
  logic          unused_lo_bits;

  // Word-address bits [1:0] never take part in matching or writes.
  assign unused_lo_bits = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};

  // Drain/enqueue decisions and next-state for pointers, count, valid bits, starve.
  always_comb begin
    not_empty = (count_q != '0);
    starved   = (starve_q == SW'(STARVE_MAX));
    drain     = not_empty & (~bus.ld_rden | bus.flush_req | starved);
    enq       = bus.st_valid & (count_q != CW'(DEPTH));

    wr_ptr_d  = enq   ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(enq) - CW'(drain);

    valid_d = valid_q;
    if (drain) valid_d[rd_ptr_q] = 1'b0;
    if (enq)   valid_d[wr_ptr_q] = 1'b1;

    starve_d = starve_q;
    if (drain || !not_empty)          starve_d = '0;
    else if (bus.ld_rden && !starved) starve_d = starve_q + SW'(1);
  end

  // Oldest-to-youngest scan so the last match seen is the youngest one.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == bus.ld_addr[DCCM_BITS-1:2])) begin
        hit_any  = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign bus.st_ready        = (count_q != CW'(DEPTH));
  assign bus.wb_count        = count_q;
  assign bus.wb_idle         = ~not_empty;
  assign bus.dccm_wren       = drain;
  assign bus.ld_stall        = bus.ld_rden & drain;
  assign bus.dccm_wr_addr_lo = not_empty ? {addr_q[rd_ptr_q], 2'b00} : '0;
  assign bus.dccm_wr_data_lo = not_empty ? data_q[rd_ptr_q] : '0;
  assign bus.fwd_hit         = bus.ld_rden & hit_any;
  assign bus.fwd_data        = (bus.ld_rden & hit_any) ? hit_data : '0;

  // Control state: pointers, occupancy, valid bits and starvation counter.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      starve_q <= starve_d;
    end
  end

  // Entry storage, written at the tail on enqueue.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (enq) begin
      addr_q[wr_ptr_q] <= bus.st_addr[DCCM_BITS-1:2];
      data_q[wr_ptr_q] <= bus.st_data;
    end
  end
endmodule

// File: tb/tb_eh2_lsu_dccm_wrbuf.sv
// Directed bench for the DCCM write buffer.
module tb_eh2_lsu_dccm_wrbuf;
  localparam int unsigned AB = 16;
  localparam int unsigned DW = 39;
  localparam int unsigned DP = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eh2_lsu_dccm_wrbuf_if #(.DCCM_BITS(AB), .DCCM_FDATA_WIDTH(DW), .DEPTH(DP)) bus();

  eh2_lsu_dccm_wrbuf #(.DCCM_BITS(AB), .DCCM_FDATA_WIDTH(DW), .DEPTH(DP), .STARVE_MAX(7)) u_dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.ld_rden   = 1'b0;
    bus.ld_addr   = '0;
    bus.flush_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;
    tick();
    #2;
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready got=%b exp=1", bus.st_ready); end
    checks++; if (bus.wb_idle !== 1'b1) begin failures++; $display("FAIL reset_wb_idle got=%b exp=1", bus.wb_idle); end
    checks++; if (bus.dccm_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", bus.dccm_wren); end
    checks++; if (bus.wb_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.wb_count); end
    checks++; if (bus.fwd_hit !== 1'b0 || bus.ld_stall !== 1'b0) begin failures++; $display("FAIL reset_hit_stall got=%b%b exp=00", bus.fwd_hit, bus.ld_stall); end
    checks++; if (bus.dccm_wr_addr_lo !== 16'h0 || bus.dccm_wr_data_lo !== 39'h0 || bus.fwd_data !== 39'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.dccm_wr_addr_lo, bus.dccm_wr_data_lo, bus.fwd_data); end
  endtask

  task automatic test_single_store();
    tick();
    bus.st_valid = 1'b1; bus.st_addr = 16'h0104; bus.st_data = 39'h12_3456789A;
    #2;
    checks++; if (bus.dccm_wren !== 1'b0) begin failures++; $display("FAIL single_enq_cycle_wren got=%b exp=0", bus.dccm_wren); end
    tick();
    bus.st_valid = 1'b0;
    #2;
    checks++; if (bus.dccm_wren !== 1'b1) begin failures++; $display("FAIL single_wren got=%b exp=1", bus.dccm_wren); end
    checks++; if (bus.dccm_wr_addr_lo !== 16'h0104) begin failures++; $display("FAIL single_addr got=%h exp=0104", bus.dccm_wr_addr_lo); end
    checks++; if (bus.dccm_wr_data_lo !== 39'h12_3456789A) begin failures++; $display("FAIL single_data got=%h exp=123456789a", bus.dccm_wr_data_lo); end
    checks++; if (bus.wb_count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", bus.wb_count); end
    tick();
    #2;
    checks++; if (bus.wb_count !== 3'd0 || bus.dccm_wren !== 1'b0) begin failures++; $display("FAIL single_after got=cnt%0d/wren%b exp=cnt0/wren0", bus.wb_count, bus.dccm_wren); end
    // Low address bits must be dropped on the DCCM write
    tick();
    bus.st_valid = 1'b1; bus.st_addr = 16'h0107; bus.st_data = 39'h00_CAFEF00D;
    tick();
    bus.st_valid = 1'b0;
    #2;
    checks++; if (bus.dccm_wr_addr_lo !== 16'h0104 || bus.dccm_wren !== 1'b1) begin failures++; $display("FAIL lowbits_addr got=%h/%b exp=0104/1", bus.dccm_wr_addr_lo, bus.dccm_wren); end
    tick();
  endtask

  task automatic test_starve();
    logic [2:0] exp_cnt;
    logic       exp_rdy, exp_wren;
    for (int k = 0; k < 10; k++) begin
      int s;
      s = (k < 4) ? k : 4;
      bus.st_valid = 1'b1;
      bus.st_addr  = 16'h0010 + 16'(4 * s);
      bus.st_data  = 39'h100 + 39'(s);
      bus.ld_rden  = 1'b1;
      bus.ld_addr  = 16'h0F00;
      exp_cnt  = (k == 9) ? 3'd3 : ((k < 4) ? 3'(k) : 3'd4);
      exp_rdy  = (k < 4) || (k == 9);
      exp_wren = (k == 8);
      #2;
      checks++; if (bus.wb_count !== exp_cnt) begin failures++; $display("FAIL starve_count k=%0d got=%0d exp=%0d", k, bus.wb_count, exp_cnt); end
      checks++; if (bus.st_ready !== exp_rdy) begin failures++; $display("FAIL starve_ready k=%0d got=%b exp=%b", k, bus.st_ready, exp_rdy); end
      checks++; if (bus.dccm_wren !== exp_wren || bus.ld_stall !== exp_wren) begin
        failures++; $display("FAIL starve_wren_stall k=%0d got=%b%b exp=%b%b", k, bus.dccm_wren, bus.ld_stall, exp_wren, exp_wren); end
      if (k == 8) begin
        checks++; if (bus.dccm_wr_addr_lo !== 16'h0010 || bus.dccm_wr_data_lo !== 39'h100) begin
          failures++; $display("FAIL starve_forced_head got=%h/%h exp=0010/100", bus.dccm_wr_addr_lo, bus.dccm_wr_data_lo); end
      end
      tick();
    end
    bus.st_valid = 1'b0;
    bus.ld_rden  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #2;
      checks++; if (bus.dccm_wren !== 1'b1 || bus.ld_stall !== 1'b0) begin failures++; $display("FAIL order_wren j=%0d got=%b%b exp=10", j, bus.dccm_wren, bus.ld_stall); end
      checks++; if (bus.dccm_wr_addr_lo !== 16'h0014 + 16'(4 * j) || bus.dccm_wr_data_lo !== 39'h101 + 39'(j)) begin
        failures++; $display("FAIL order_head j=%0d got=%h/%h exp=%h/%h", j, bus.dccm_wr_addr_lo, bus.dccm_wr_data_lo, 16'h0014 + 16'(4 * j), 39'h101 + 39'(j)); end
      tick();
    end
    #2;
    checks++; if (bus.wb_idle !== 1'b1 || bus.dccm_wren !== 1'b0) begin failures++; $display("FAIL starve_end_idle got=%b/%b exp=1/0", bus.wb_idle, bus.dccm_wren); end
    tick();
  endtask

  task automatic test_forward();
    logic [DW-1:0] da, db;
    da = 39'h0A_AAAA0001;
    db = 39'h0B_BBBB0002;
    bus.st_valid = 1'b1; bus.st_addr = 16'h0200; bus.st_data = da;
    bus.ld_rden = 1'b1; bus.ld_addr = 16'h0202;
    #2;
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 39'h0) begin failures++; $display("FAIL fwd_enq_invisible got=%b/%h exp=0/0", bus.fwd_hit, bus.fwd_data); end
    tick();
    bus.st_data = db;
    #2;
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== da) begin failures++; $display("FAIL fwd_first got=%b/%h exp=1/%h", bus.fwd_hit, bus.fwd_data, da); end
    tick();
    bus.st_valid = 1'b0;
    #2;
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== db) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=1/%h", bus.fwd_hit, bus.fwd_data, db); end
    checks++; if (bus.wb_count !== 3'd2) begin failures++; $display("FAIL fwd_count got=%0d exp=2", bus.wb_count); end
    tick();
    bus.ld_addr = 16'h0300;
    #2;
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 39'h0) begin failures++; $display("FAIL fwd_miss got=%b/%h exp=0/0", bus.fwd_hit, bus.fwd_data); end
    tick();
    bus.ld_rden = 1'b0; bus.ld_addr = 16'h0200;
    #2;
    checks++; if (bus.fwd_hit !== 1'b0) begin failures++; $display("FAIL fwd_no_rden got=%b exp=0", bus.fwd_hit); end
    checks++; if (bus.dccm_wren !== 1'b1 || bus.dccm_wr_data_lo !== da) begin failures++; $display("FAIL fwd_drain_a got=%b/%h exp=1/%h", bus.dccm_wren, bus.dccm_wr_data_lo, da); end
    tick();
    #2;
    checks++; if (bus.dccm_wren !== 1'b1 || bus.dccm_wr_data_lo !== db || bus.dccm_wr_addr_lo !== 16'h0200) begin
      failures++; $display("FAIL fwd_drain_b got=%b/%h/%h exp=1/0200/%h", bus.dccm_wren, bus.dccm_wr_addr_lo, bus.dccm_wr_data_lo, db); end
    tick();
    #2;
    checks++; if (bus.wb_idle !== 1'b1) begin failures++; $display("FAIL fwd_idle got=%b exp=1", bus.wb_idle); end
    tick();
  endtask

  task automatic test_flush();
    bus.st_valid = 1'b1; bus.st_addr = 16'h0040; bus.st_data = 39'h7C_00000C0C;
    bus.ld_rden = 1'b1; bus.ld_addr = 16'h0040;
    tick();
    bus.st_addr = 16'h0044; bus.st_data = 39'h7D_00000D0D;
    #2;
    checks++; if (bus.dccm_wren !== 1'b0) begin failures++; $display("FAIL flush_pre_blocked got=%b exp=0", bus.dccm_wren); end
    tick();
    bus.st_valid = 1'b0; bus.flush_req = 1'b1;
    #2;
    checks++; if (bus.dccm_wren !== 1'b1 || bus.ld_stall !== 1'b1 || bus.dccm_wr_data_lo !== 39'h7C_00000C0C) begin
      failures++; $display("FAIL flush_first got=%b%b/%h exp=11/7c00000c0c", bus.dccm_wren, bus.ld_stall, bus.dccm_wr_data_lo); end
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 39'h7C_00000C0C) begin
      failures++; $display("FAIL flush_draining_fwd got=%b/%h exp=1/7c00000c0c", bus.fwd_hit, bus.fwd_data); end
    tick();
    #2;
    checks++; if (bus.dccm_wren !== 1'b1 || bus.ld_stall !== 1'b1 || bus.dccm_wr_addr_lo !== 16'h0044) begin
      failures++; $display("FAIL flush_second got=%b%b/%h exp=11/0044", bus.dccm_wren, bus.ld_stall, bus.dccm_wr_addr_lo); end
    tick();
    #2;
    checks++; if (bus.wb_idle !== 1'b1 || bus.dccm_wren !== 1'b0 || bus.ld_stall !== 1'b0) begin
      failures++; $display("FAIL flush_idle got=%b/%b/%b exp=1/0/0", bus.wb_idle, bus.dccm_wren, bus.ld_stall); end
    bus.flush_req = 1'b0; bus.ld_rden = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.ld_rden = 1'b1; bus.ld_addr = 16'h0F00;
    for (int k = 0; k < 3; k++) begin
      bus.st_valid = 1'b1; bus.st_addr = 16'h0080 + 16'(4 * k); bus.st_data = 39'h200 + 39'(k);
      tick();
    end
    bus.st_valid = 1'b0; bus.ld_rden = 1'b0;
    #2;
    checks++; if (bus.dccm_wren !== 1'b1 || bus.wb_count !== 3'd3) begin failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/3", bus.dccm_wren, bus.wb_count); end
    #1 rst_l = 1'b0;
    #1;
    checks++; if (bus.dccm_wren !== 1'b0 || bus.wb_count !== 3'd0) begin failures++; $display("FAIL rstmid_async got=%b/%0d exp=0/0", bus.dccm_wren, bus.wb_count); end
    checks++; if (bus.st_ready !== 1'b1 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL rstmid_flags got=%b/%b exp=1/1", bus.st_ready, bus.wb_idle); end
    #2 rst_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #2;
      checks++; if (bus.dccm_wren !== 1'b0 || bus.wb_idle !== 1'b1) begin failures++; $display("FAIL rstmid_after k=%0d got=%b/%b exp=0/1", k, bus.dccm_wren, bus.wb_idle); end
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_starve();
    test_forward();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
